// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a one-cold column drive, debounces a single-row
// press and its release, and strobes key_valid once per accepted key.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  // Nibble (row*4 + col) holds the hex code printed on that key.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t        state_q;
  logic [1:0]    col_q;
  logic [3:0]    cols_q;
  logic [3:0]    row_pat_q;
  logic [3:0]    key_q;
  logic          key_valid_q;
  logic [SW-1:0] settle_q;
  logic [DW-1:0] deb_q;
  logic [DW-1:0] rel_q;

  logic [3:0]    only_low;
  logic          single_low;
  logic [1:0]    row_idx;
  logic [3:0]    key_code;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign only_low[gi] = (rows == (4'hF ^ (4'h1 << gi)));
    end
  endgenerate

  // Ghosting or multi-press leaves two or more rows low and is never accepted.
  assign single_low = |only_low;

  always_comb begin
    row_idx = 2'd3;
    case (row_pat_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    key_code = KEYMAP[{row_idx, col_q, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    key_valid_q <= 1'b0;
    if (reset) begin
      state_q   <= ST_SCAN;
      col_q     <= 2'd0;
      cols_q    <= 4'b1110;
      row_pat_q <= 4'hF;
      key_q     <= 4'h0;
      settle_q  <= '0;
      deb_q     <= '0;
      rel_q     <= '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            if (single_low) begin
              row_pat_q <= rows;
              deb_q     <= '0;
              state_q   <= ST_DEBOUNCE;
            end else begin
              col_q  <= col_q + 2'd1;
              cols_q <= {cols_q[2:0], cols_q[3]};
            end
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (rows != row_pat_q) begin
            settle_q <= '0;
            state_q  <= ST_SCAN;
          end else if (deb_q == DEB_LAST) begin
            key_valid_q <= 1'b1;
            key_q       <= key_code;
            rel_q       <= '0;
            state_q     <= ST_HELD;
          end else begin
            deb_q <= deb_q + DW'(1);
          end
        end
        ST_HELD: begin
          // Any low row restarts the release count, including a second key.
          if (rows != 4'hF) begin
            rel_q <= '0;
          end else if (rel_q == DEB_LAST) begin
            col_q    <= col_q + 2'd1;
            cols_q   <= {cols_q[2:0], cols_q[3]};
            settle_q <= '0;
            state_q  <= ST_SCAN;
          end else begin
            rel_q <= rel_q + DW'(1);
          end
        end
        default: begin
          settle_q <= '0;
          state_q  <= ST_SCAN;
        end
      endcase
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives rows from the pressed-key set
// and the current column; expectations come from scan timing arithmetic and a key table.
module tb_keypad_scanner;
  localparam int SETTLE = 3;
  localparam int DEB    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows = 4'hF;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         pulse_cyc = -1;
  logic [3:0] pulse_key = 4'h0;
  int         consec_err = 0;
  int         cols_err = 0;
  int         key_err = 0;
  logic       prev_kv = 1'b0;
  logic [3:0] prev_key = 4'h0;
  logic [15:0] pressed = 16'h0;
  logic [3:0] colsh [0:1023];
  logic [3:0] code_tbl [0:15];

  function automatic logic [3:0] one_cold(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return ~v;
  endfunction

  // Physical matrix: a pressed key pulls its row low only while its column is driven.
  task automatic update_rows();
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (pressed[ri*4+ci] && !cols[ci]) r[ri] = 1'b0;
    rows = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= 0 && cyc < 1024) colsh[cyc] = cols;
    if ($countones(~cols) != 1) cols_err++;
    if (key_valid === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
      pulse_key = key;
      $display("cycle %0d: key_valid key=%h", cyc, key);
    end
    if (key_valid === 1'b1 && prev_kv === 1'b1) consec_err++;
    if (key_valid !== 1'b1 && !reset && key !== prev_key) key_err++;
    prev_kv  = key_valid;
    prev_key = key;
    update_rows();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pressed = 16'h0;
    tick();
    tick();
    reset     = 1'b0;
    cyc       = 0;
    pulses    = 0;
    pulse_cyc = -1;
    prev_kv   = 1'b0;
    prev_key  = key;
  endtask

  task automatic test_reset();
    logic [3:0] exp_c;
    do_reset();
    n_cmp++; if (cols !== 4'b1110) begin n_err++; $display("FAIL reset_cols: got %b expected %b", cols, 4'b1110); end
    n_cmp++; if (key !== 4'h0) begin n_err++; $display("FAIL reset_key: got %h expected 0", key); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_kv: got %b expected 0", key_valid); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_c = one_cold((k / SETTLE) % 4);
      n_cmp++; if (cols !== exp_c) begin n_err++; $display("FAIL idle_cols@%0d: got %b expected %b", k, cols, exp_c); end
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    n_cmp++; if (key !== 4'h0) begin n_err++; $display("FAIL idle_key: got %h expected 0", key); end
  endtask

  task automatic test_single_key();
    int exp_pulse;
    do_reset();
    pressed[1*4+2] = 1'b1;
    update_rows();
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (cyc == 40) begin pressed = 16'h0; update_rows(); end
    end
    exp_pulse = SETTLE * 3 + DEB;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", pulses); end
    n_cmp++; if (pulse_cyc !== exp_pulse) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", pulse_cyc, exp_pulse); end
    n_cmp++; if (pulse_key !== 4'h6) begin n_err++; $display("FAIL single_code: got %h expected 6", pulse_key); end
    n_cmp++; if (key !== 4'h6) begin n_err++; $display("FAIL single_key_hold: got %h expected 6", key); end
    n_cmp++; if (colsh[30] !== 4'b1011) begin n_err++; $display("FAIL single_held_col: got %b expected 1011", colsh[30]); end
    n_cmp++; if (colsh[40 + DEB - 1] !== 4'b1011) begin n_err++; $display("FAIL single_release_early: got %b expected 1011", colsh[40 + DEB - 1]); end
    n_cmp++; if (colsh[40 + DEB] !== 4'b0111) begin n_err++; $display("FAIL single_resume_col3: got %b expected 0111", colsh[40 + DEB]); end
  endtask

  task automatic test_bounce();
    int exp_pulse;
    do_reset();
    pressed[0] = 1'b1;
    update_rows();
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (cyc == 4) pressed[0] = 1'b0;
      if (cyc == 5) pressed[0] = 1'b1;
      if (cyc == 25) pressed[0] = 1'b0;
      update_rows();
    end
    exp_pulse = 5 + SETTLE + DEB;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL bounce_count: got %0d expected 1", pulses); end
    n_cmp++; if (pulse_cyc !== exp_pulse) begin n_err++; $display("FAIL bounce_latency: got %0d expected %0d", pulse_cyc, exp_pulse); end
    n_cmp++; if (pulse_key !== 4'h1) begin n_err++; $display("FAIL bounce_code: got %h expected 1", pulse_key); end
    n_cmp++; if (colsh[25 + DEB] !== 4'b1101) begin n_err++; $display("FAIL bounce_resume: got %b expected 1101", colsh[25 + DEB]); end
  endtask

  task automatic test_multi();
    int exp_pulse;
    int kk;
    do_reset();
    pressed[0*4+1] = 1'b1;
    pressed[1*4+1] = 1'b1;
    update_rows();
    repeat (30) tick();
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL multi_no_pulse: got %0d expected 0", pulses); end
    n_cmp++; if (colsh[6] !== 4'b1011) begin n_err++; $display("FAIL multi_advance: got %b expected 1011", colsh[6]); end
    n_cmp++; if (colsh[30] !== one_cold((30 / SETTLE) % 4)) begin n_err++; $display("FAIL multi_advance2: got %b expected %b", colsh[30], one_cold((30 / SETTLE) % 4)); end
    pressed[1*4+1] = 1'b0;
    update_rows();
    kk = 30;
    while (!((kk % SETTLE) == 0 && ((kk / SETTLE) % 4) == 1)) kk++;
    exp_pulse = kk + SETTLE + DEB;
    repeat (30) tick();
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL multi_single_count: got %0d expected 1", pulses); end
    n_cmp++; if (pulse_cyc !== exp_pulse) begin n_err++; $display("FAIL multi_latency: got %0d expected %0d", pulse_cyc, exp_pulse); end
    n_cmp++; if (pulse_key !== 4'h2) begin n_err++; $display("FAIL multi_code: got %h expected 2", pulse_key); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pressed[3*4+3] = 1'b1;
    update_rows();
    while (cyc < 4 * SETTLE + 4) tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (cols !== 4'b1110) begin n_err++; $display("FAIL midrst_cols: got %b expected 1110", cols); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL midrst_kv: got %b expected 0", key_valid); end
    n_cmp++; if (key !== 4'h0) begin n_err++; $display("FAIL midrst_key: got %h expected 0", key); end
    reset   = 1'b0;
    pressed = 16'h0;
    update_rows();
    repeat (20) tick();
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
    n_cmp++; if (key !== 4'h0) begin n_err++; $display("FAIL midrst_key_after: got %h expected 0", key); end
  endtask

  task automatic test_held_second();
    int exp_pulse;
    do_reset();
    pressed[3*4+0] = 1'b1;
    update_rows();
    for (int k = 1; k <= 115; k++) begin
      tick();
      if (cyc == 30) pressed[0*4+0] = 1'b1;
      if (cyc == 40) pressed[1*4+2] = 1'b1;
      if (cyc == 60) begin pressed[0*4+0] = 1'b0; pressed[1*4+2] = 1'b0; end
      if (cyc == 100) pressed = 16'h0;
      update_rows();
    end
    exp_pulse = SETTLE + DEB;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL held_count: got %0d expected 1", pulses); end
    n_cmp++; if (pulse_cyc !== exp_pulse) begin n_err++; $display("FAIL held_latency: got %0d expected %0d", pulse_cyc, exp_pulse); end
    n_cmp++; if (pulse_key !== 4'hE) begin n_err++; $display("FAIL held_code: got %h expected e", pulse_key); end
    n_cmp++; if (key !== 4'hE) begin n_err++; $display("FAIL held_key_hold: got %h expected e", key); end
    n_cmp++; if (colsh[100 + DEB - 1] !== 4'b1110) begin n_err++; $display("FAIL held_col_kept: got %b expected 1110", colsh[100 + DEB - 1]); end
    n_cmp++; if (colsh[100 + DEB] !== 4'b1101) begin n_err++; $display("FAIL held_resume: got %b expected 1101", colsh[100 + DEB]); end
  endtask

  task automatic test_random();
    int r, c, r2, hold, rel, idle, p0, exp_n;
    logic multi;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      idle  = $urandom_range(0, 11);
      r     = $urandom_range(0, 3);
      c     = $urandom_range(0, 3);
      multi = ($urandom_range(0, 3) == 0);
      hold  = $urandom_range(30, 60);
      rel   = $urandom_range(25, 40);
      repeat (idle) tick();
      p0 = pulses;
      pressed = 16'h0;
      pressed[r*4+c] = 1'b1;
      if (multi) begin
        r2 = (r + 1 + $urandom_range(0, 2)) % 4;
        pressed[r2*4+c] = 1'b1;
      end
      update_rows();
      repeat (hold) tick();
      pressed = 16'h0;
      update_rows();
      repeat (rel) tick();
      exp_n = multi ? 0 : 1;
      $display("random %0d: r=%0d c=%0d multi=%0d hold=%0d pulses=%0d", it, r, c, multi, hold, pulses - p0);
      n_cmp++; if (pulses - p0 !== exp_n) begin n_err++; $display("FAIL rand_count[%0d]: got %0d expected %0d", it, pulses - p0, exp_n); end
      if (!multi) begin
        n_cmp++; if (pulse_key !== code_tbl[r*4+c]) begin n_err++; $display("FAIL rand_code[%0d]: got %h expected %h", it, pulse_key, code_tbl[r*4+c]); end
      end
    end
  endtask

  task automatic test_invariants();
    n_cmp++; if (consec_err !== 0) begin n_err++; $display("FAIL kv_back_to_back: got %0d expected 0", consec_err); end
    n_cmp++; if (cols_err !== 0) begin n_err++; $display("FAIL cols_one_cold: got %0d bad cycles expected 0", cols_err); end
    n_cmp++; if (key_err !== 0) begin n_err++; $display("FAIL key_stable: got %0d changes expected 0", key_err); end
  endtask

  initial begin
    code_tbl = '{4'h1, 4'h2, 4'h3, 4'hA,
                 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC,
                 4'hE, 4'h0, 4'hF, 4'hD};
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_held_second();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
